// File: rtl/alu_mult_seq.sv
// Shift-add multiplier controller for mult/multu. It drives the shared alu32
// as its adder for 32 iterations, then holds the 64-bit product in hi/lo.
module alu_mult_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] ADD_GIN = 3'b010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_gin,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_hi, r_lo, r_mcand;
    logic [CW-1:0]      r_count;
    logic               r_neg;

    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_negated;

    // 0x80000000 negates to itself, which reads correctly as an unsigned magnitude.
    assign w_abs_a   = op_a[WIDTH-1] ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
    assign w_abs_b   = op_b[WIDTH-1] ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
    assign w_carry   = (alu_result < r_hi);
    assign w_negated = ~{r_hi, r_lo} + {{(2*WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_ITER;
            S_ITER: if (r_count == LAST) w_next = r_neg ? S_FIX : S_DONE;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mcand <= is_signed ? w_abs_a : op_a;
                    r_lo    <= is_signed ? w_abs_b : op_b;
                    r_hi    <= '0;
                    r_count <= '0;
                    r_neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                end
                // The ALU sum drops its carry; recover it with a local compare.
                S_ITER: begin
                    r_hi    <= {w_carry, alu_result[WIDTH-1:1]};
                    r_lo    <= {alu_result[0], r_lo[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                end
                S_FIX: {r_hi, r_lo} <= w_negated;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_gin = ADD_GIN;
        if (r_state == S_ITER) begin
            alu_a = r_hi;
            alu_b = r_lo[0] ? r_mcand : '0;
        end
    end

    assign busy = (r_state == S_ITER) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq: vector table plus hand-written control sequences.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        reset, start, is_signed;
    logic [31:0] op_a, op_b, alu_a, alu_b, alu_result, hi, lo;
    logic [2:0]  alu_gin;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    alu_mult_seq #(.WIDTH(32), .ADD_GIN(3'b010)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_gin(alu_gin), .alu_result(alu_result), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    // Shared alu32 stand-in: adds only when asked for add.
    assign alu_result = (alu_gin == 3'b010) ? alu_a + alu_b : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a, b, ehi, elo;
        int          elat;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done; lat counts edges from the start edge (1) to done.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy, output logic nz_b);
        start = 1'b1; is_signed = s; op_a = a; op_b = b;
        tick;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; is_signed = ~s;
        lat = 1; nbusy = 0; nz_b = 1'b0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            if (busy && alu_b != 0) nz_b = 1'b1;
            tick;
            lat++;
        end
    endtask

    initial begin
        int lat, nbusy;
        logic nz_b;
        logic [31:0] hold_hi, hold_lo;

        vt[0] = '{1'b0, 32'd50,        32'd100,       32'h0000_0000, 32'h0000_1388, 33};
        vt[1] = '{1'b0, 32'd0,         32'd0,         32'h0000_0000, 32'h0000_0000, 33};
        vt[2] = '{1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFF6, 32'h0000_0000, 32'h0000_0032, 33};
        vt[3] = '{1'b1, 32'hFFFF_FFFB, 32'h0000_000A, 32'hFFFF_FFFF, 32'hFFFF_FFCE, 34};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vt[5] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vt[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 34};
        vt[7] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 33};
        vt[8] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
        vt[9] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 34};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        tick; tick;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_gin", {61'd0, alu_gin}, 64'd2);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].sgn, vt[i].a, vt[i].b, lat, nbusy, nz_b);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].elat));
            chk($sformatf("v%0d_prod", i), {hi, lo}, {vt[i].ehi, vt[i].elo});
            chk($sformatf("v%0d_busy", i), 64'(nbusy), 64'(vt[i].elat - 1));
            if (vt[i].b == 0 && !vt[i].sgn)
                chk($sformatf("v%0d_alub_zero", i), {63'd0, nz_b}, 64'd0);
            tick;
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d_idle_alu", i), {alu_a, alu_b}, 64'd0);
            chk($sformatf("v%0d_hold", i), {hi, lo}, {vt[i].ehi, vt[i].elo});
        end

        // start re-pulsed mid-iteration must be ignored
        start = 1'b1; is_signed = 1'b0; op_a = 32'd50; op_b = 32'd100;
        tick;
        start = 1'b0;
        for (int k = 0; k < 9; k++) tick;
        start = 1'b1; op_a = 32'd7; op_b = 32'd9; is_signed = 1'b1;
        tick;
        start = 1'b0;
        lat = 11;
        while (!done && lat < 60) begin tick; lat++; end
        chk("repulse_lat", 64'(lat), 64'd33);
        chk("repulse_prod", {hi, lo}, {32'd0, 32'h0000_1388});

        // start held during DONE must not launch a new operation
        start = 1'b1; op_a = 32'd3; op_b = 32'd3; is_signed = 1'b0;
        hold_hi = hi; hold_lo = lo;
        tick;
        start = 1'b0;
        tick;
        chk("done_start_busy", {63'd0, busy}, 64'd0);
        chk("done_start_hold", {hi, lo}, {hold_hi, hold_lo});

        // asynchronous reset in the middle of an iteration
        start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; is_signed = 1'b0;
        tick;
        start = 1'b0;
        for (int k = 0; k < 19; k++) tick;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("async_rst_prod", {hi, lo}, 64'd0);
        #1 reset = 1'b0;
        tick;

        run_op(1'b0, 32'd50, 32'd100, lat, nbusy, nz_b);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_prod", {hi, lo}, {32'd0, 32'h0000_1388});
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
